control_posicion_rana: RTL and testbench

Frog position and outcome controller for the Frogger game, sitting directly upstream of the frog-life sequencer. It arms the frog at the start cell while the sequencer requests it (RANA_INI). It moves the frog one cell per button press and checks the frog's cell against the vehicle obstacle map. It issues single-cycle win/lose pulses that drive the sequencer's GANO/PERDIO inputs.

---
 rtl/control_posicion_rana_if.sv | 57 +++++
 rtl/control_posicion_rana.sv | 150 +++++++++++++++
 tb/tb_control_posicion_rana.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/control_posicion_rana_if.sv
`default_nettype none
// ============================================================================
// Module      : control_posicion_rana_if
// Description : Bundle of the frog controller's game-side signals.
//               Master side (game logic / bench) drives the arming level,
//               the buttons, the time-base tick and the obstacle map.
//               Slave side (control_posicion_rana) returns the frog
//               position, the win/lose pulses, the active flag and the
//               remaining time.
//   CPR_RANA_INI    : level, 1 = hold frog armed at start cell
//   CPR_BTN_*       : debounced button levels
//   CPR_TICK        : one-cycle time-base pulse
//   CPR_MAPA        : obstacle map, bit fila*NUM_COLS+col = occupied
//   CPR_FILA_OUT    : frog row
//   CPR_COL_OUT     : frog column
//   CPR_GANO_OUT    : one-cycle win pulse
//   CPR_PERDIO_OUT  : one-cycle lose pulse
//   CPR_ACTIVA_OUT  : 1 while the frog is in play
//   CPR_TIEMPO_OUT  : remaining ticks
// Revision    : 1.0 - initial release
// ============================================================================
interface control_posicion_rana_if #(
  parameter int DATAWIDTH_FILA   = 3,
  parameter int DATAWIDTH_COL    = 3,
  parameter int NUM_FILAS        = 8,
  parameter int NUM_COLS         = 8,
  parameter int DATAWIDTH_TIEMPO = 6
) ();
  logic                          CPR_RANA_INI;
  logic                          CPR_BTN_UP;
  logic                          CPR_BTN_DOWN;
  logic                          CPR_BTN_LEFT;
  logic                          CPR_BTN_RIGHT;
  logic                          CPR_TICK;
  logic [NUM_FILAS*NUM_COLS-1:0] CPR_MAPA;
  logic [DATAWIDTH_FILA-1:0]     CPR_FILA_OUT;
  logic [DATAWIDTH_COL-1:0]      CPR_COL_OUT;
  logic                          CPR_GANO_OUT;
  logic                          CPR_PERDIO_OUT;
  logic                          CPR_ACTIVA_OUT;
  logic [DATAWIDTH_TIEMPO-1:0]   CPR_TIEMPO_OUT;

  modport master (
    output CPR_RANA_INI, CPR_BTN_UP, CPR_BTN_DOWN, CPR_BTN_LEFT, CPR_BTN_RIGHT,
           CPR_TICK, CPR_MAPA,
    input  CPR_FILA_OUT, CPR_COL_OUT, CPR_GANO_OUT, CPR_PERDIO_OUT,
           CPR_ACTIVA_OUT, CPR_TIEMPO_OUT
  );

  modport slave (
    input  CPR_RANA_INI, CPR_BTN_UP, CPR_BTN_DOWN, CPR_BTN_LEFT, CPR_BTN_RIGHT,
           CPR_TICK, CPR_MAPA,
    output CPR_FILA_OUT, CPR_COL_OUT, CPR_GANO_OUT, CPR_PERDIO_OUT,
           CPR_ACTIVA_OUT, CPR_TIEMPO_OUT
  );
endinterface
`default_nettype wire

// File: rtl/control_posicion_rana.sv
`default_nettype none
// ============================================================================
// Module      : control_posicion_rana
// Description : Frog position and outcome controller. Arms the frog at the
//               start cell while CPR_RANA_INI is high, moves it one cell per
//               button press (UP > DOWN > LEFT > RIGHT), checks its cell
//               against the obstacle map and emits one-cycle win/lose pulses.
// Ports       : CPR_CLOCK_50    - system clock
//               CPR_RESET_InLow - asynchronous active-low reset
//               bus             - control_posicion_rana_if.slave
//                                 (inputs: arming, buttons, tick, map;
//                                  outputs: position, pulses, active, time)
// Config      : define CPR_TIMEOUT_EN to build the play timer; otherwise
//               CPR_TIEMPO_OUT is the constant TIEMPO_MAX and CPR_TICK is
//               ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module control_posicion_rana #(
  parameter int DATAWIDTH_FILA   = 3,
  parameter int DATAWIDTH_COL    = 3,
  parameter int NUM_FILAS        = 8,
  parameter int NUM_COLS         = 8,
  parameter int COL_INICIO       = 3,
  parameter int DATAWIDTH_TIEMPO = 6,
  parameter int TIEMPO_MAX       = 45
) (
  input  wire logic               CPR_CLOCK_50,
  input  wire logic               CPR_RESET_InLow,
  control_posicion_rana_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_FILAS * NUM_COLS);

  localparam logic [DATAWIDTH_FILA-1:0]   FILA_MAX  = DATAWIDTH_FILA'(NUM_FILAS - 1);
  localparam logic [DATAWIDTH_COL-1:0]    COL_MAX   = DATAWIDTH_COL'(NUM_COLS - 1);
  localparam logic [DATAWIDTH_COL-1:0]    COL_START = DATAWIDTH_COL'(COL_INICIO);
  localparam logic [DATAWIDTH_TIEMPO-1:0] T_LOAD    = DATAWIDTH_TIEMPO'(TIEMPO_MAX);

  typedef enum logic [2:0] {
    ST_FIN    = 3'd0,
    ST_ARMADA = 3'd1,
    ST_JUEGO  = 3'd2,
    ST_GANO   = 3'd3,
    ST_PERDIO = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [DATAWIDTH_FILA-1:0] fila_q, fila_d;
  logic [DATAWIDTH_COL-1:0]  col_q, col_d;
  logic [3:0]                btn_prev_q;   // {up, down, left, right}
  logic [3:0]                w_btn;
  logic [3:0]                w_press;
  logic [IDX_W-1:0]          w_idx;
  logic                      w_hit;
  logic                      w_timeout;

  assign w_btn   = {bus.CPR_BTN_UP, bus.CPR_BTN_DOWN, bus.CPR_BTN_LEFT, bus.CPR_BTN_RIGHT};
  assign w_press = w_btn & ~btn_prev_q;
  assign w_idx   = IDX_W'(fila_q) * IDX_W'(NUM_COLS) + IDX_W'(col_q);
  assign w_hit   = bus.CPR_MAPA[w_idx];

  // Next-state / position logic. The arming request overrides every state.
  always_comb begin
    state_d = state_q;
    fila_d  = fila_q;
    col_d   = col_q;
    case (state_q)
      ST_ARMADA: state_d = ST_JUEGO;
      ST_JUEGO: begin
        if (w_hit) begin
          state_d = ST_PERDIO;
        end else if (fila_q == FILA_MAX) begin
          state_d = ST_GANO;
        end else if (w_timeout) begin
          state_d = ST_PERDIO;
        end else if (w_press[3]) begin
          if (fila_q != FILA_MAX) fila_d = fila_q + 1'b1;
        end else if (w_press[2]) begin
          if (fila_q != '0) fila_d = fila_q - 1'b1;
        end else if (w_press[1]) begin
          if (col_q != '0) col_d = col_q - 1'b1;
        end else if (w_press[0]) begin
          if (col_q != COL_MAX) col_d = col_q + 1'b1;
        end
      end
      ST_GANO:   state_d = ST_FIN;
      ST_PERDIO: state_d = ST_FIN;
      ST_FIN:    state_d = ST_FIN;
      default:   state_d = ST_FIN;
    endcase
    if (bus.CPR_RANA_INI) begin
      state_d = ST_ARMADA;
      fila_d  = '0;
      col_d   = COL_START;
    end
  end

  always_ff @(posedge CPR_CLOCK_50 or negedge CPR_RESET_InLow) begin
    if (!CPR_RESET_InLow) begin
      state_q    <= ST_FIN;
      fila_q     <= '0;
      col_q      <= COL_START;
      btn_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      fila_q     <= fila_d;
      col_q      <= col_d;
      btn_prev_q <= w_btn;
    end
  end

`ifdef CPR_TIMEOUT_EN
  logic [DATAWIDTH_TIEMPO-1:0] tiempo_q, tiempo_d;

  always_comb begin
    tiempo_d = tiempo_q;
    if (state_q == ST_JUEGO && bus.CPR_TICK && tiempo_q != '0) begin
      tiempo_d = tiempo_q - 1'b1;
    end
    if (bus.CPR_RANA_INI) begin
      tiempo_d = T_LOAD;
    end
  end

  always_ff @(posedge CPR_CLOCK_50 or negedge CPR_RESET_InLow) begin
    if (!CPR_RESET_InLow) begin
      tiempo_q <= T_LOAD;
    end else begin
      tiempo_q <= tiempo_d;
    end
  end

  assign w_timeout          = (tiempo_q == '0);
  assign bus.CPR_TIEMPO_OUT = tiempo_q;
`else
  // Without the timer the tick input has no consumer.
  logic unused_tick;
  assign unused_tick        = bus.CPR_TICK;
  assign w_timeout          = 1'b0;
  assign bus.CPR_TIEMPO_OUT = T_LOAD;
`endif

  assign bus.CPR_FILA_OUT   = fila_q;
  assign bus.CPR_COL_OUT    = col_q;
  assign bus.CPR_GANO_OUT   = (state_q == ST_GANO);
  assign bus.CPR_PERDIO_OUT = (state_q == ST_PERDIO);
  assign bus.CPR_ACTIVA_OUT = (state_q == ST_JUEGO);

endmodule
`default_nettype wire

// File: tb/tb_control_posicion_rana.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_posicion_rana
// Description : Self-checking bench for control_posicion_rana. A table of
//               per-cycle {inputs, expected outputs} records drives arming,
//               moves, clamping, goal and collision cases; hand sequences
//               cover the timer, reset values and mid-game reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_posicion_rana;

  logic clk;
  logic rst_n;

  control_posicion_rana_if bus ();

  control_posicion_rana dut (
    .CPR_CLOCK_50    (clk),
    .CPR_RESET_InLow (rst_n),
    .bus             (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ini, up, down, left, right;
    logic [63:0] mapa;
    logic [2:0]  fila, col;
    logic        gano, perdio, activa;
  } vec_t;

  vec_t vecs[$];
  int   n_err;
  int   n_chk;

  function automatic void add(input logic ini, input logic u, input logic d,
                              input logic l, input logic r, input logic [63:0] m,
                              input logic [2:0] f, input logic [2:0] c,
                              input logic g, input logic p, input logic a);
    vec_t v;
    v.ini = ini; v.up = u; v.down = d; v.left = l; v.right = r; v.mapa = m;
    v.fila = f; v.col = c; v.gano = g; v.perdio = p; v.activa = a;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ini, input logic u, input logic d,
                       input logic l, input logic r, input logic t,
                       input logic [63:0] m);
    bus.CPR_RANA_INI  = ini;
    bus.CPR_BTN_UP    = u;
    bus.CPR_BTN_DOWN  = d;
    bus.CPR_BTN_LEFT  = l;
    bus.CPR_BTN_RIGHT = r;
    bus.CPR_TICK      = t;
    bus.CPR_MAPA      = m;
  endtask

  function automatic logic [8:0] outs();
    return {bus.CPR_FILA_OUT, bus.CPR_COL_OUT, bus.CPR_GANO_OUT,
            bus.CPR_PERDIO_OUT, bus.CPR_ACTIVA_OUT};
  endfunction

  localparam logic [63:0] M0   = 64'd0;
  localparam logic [63:0] M11  = 64'd1 << 11;  // row 1, col 3
  localparam logic [63:0] M3   = 64'd1 << 3;   // row 0, col 3
  localparam logic [63:0] M59  = 64'd1 << 59;  // row 7, col 3

  initial begin
    int pulses;
    n_err = 0;
    n_chk = 0;

    // ---------------- table construction ----------------
    // Arm, then moves with priority and clamping.
    add(1,0,0,0,0,M0, 0,3, 0,0,0);
    add(0,0,0,0,0,M0, 0,3, 0,0,1);
    add(0,1,0,0,0,M0, 1,3, 0,0,1);
    add(0,0,0,0,0,M0, 1,3, 0,0,1);
    add(0,1,0,1,0,M0, 2,3, 0,0,1);   // UP wins over LEFT
    add(0,0,0,0,0,M0, 2,3, 0,0,1);
    add(0,0,0,1,0,M0, 2,2, 0,0,1);
    add(0,0,0,0,0,M0, 2,2, 0,0,1);
    add(0,0,0,1,0,M0, 2,1, 0,0,1);
    add(0,0,0,0,0,M0, 2,1, 0,0,1);
    add(0,0,0,1,0,M0, 2,0, 0,0,1);
    add(0,0,0,0,0,M0, 2,0, 0,0,1);
    add(0,0,0,1,0,M0, 2,0, 0,0,1);   // clamp at col 0
    add(0,0,0,0,0,M0, 2,0, 0,0,1);
    add(0,0,0,0,1,M0, 2,1, 0,0,1);
    add(0,0,0,0,0,M0, 2,1, 0,0,1);
    add(0,0,1,0,0,M0, 1,1, 0,0,1);
    add(0,0,0,0,0,M0, 1,1, 0,0,1);
    add(0,0,1,0,0,M0, 0,1, 0,0,1);
    add(0,0,0,0,0,M0, 0,1, 0,0,1);
    add(0,0,1,0,0,M0, 0,1, 0,0,1);   // clamp at row 0
    add(0,0,0,0,0,M0, 0,1, 0,0,1);
    // Climb to goal: 7 presses, win pulse one edge after the last.
    for (int k = 1; k <= 7; k++) begin
      add(0,1,0,0,0,M0, 3'(k),1, 0,0,1);
      if (k < 7) add(0,0,0,0,0,M0, 3'(k),1, 0,0,1);
    end
    add(0,0,0,0,0,M0, 7,1, 1,0,0);   // GANO pulse
    add(1,0,0,0,0,M0, 0,3, 0,0,0);   // arming during GANO -> ARMADA
    add(0,0,0,0,0,M0, 0,3, 0,0,1);
    // Collision after a move, then re-arm during PERDIO.
    add(1,0,0,0,0,M11, 0,3, 0,0,0);
    add(0,0,0,0,0,M11, 0,3, 0,0,1);
    add(0,1,0,0,0,M11, 1,3, 0,0,1);
    add(0,0,0,0,0,M11, 1,3, 0,1,0);  // PERDIO pulse
    add(1,0,0,0,0,M0,  0,3, 0,0,0);
    add(0,0,0,0,0,M0,  0,3, 0,0,1);
    // Obstacle appearing on the frog's cell without a move.
    add(0,0,0,0,0,M3, 0,3, 0,1,0);
    add(0,0,0,0,0,M3, 0,3, 0,0,0);   // FIN
    add(0,0,0,0,0,M0, 0,3, 0,0,0);   // FIN persists
    // UP held through arming yields no move until re-pressed.
    add(1,1,0,0,0,M0, 0,3, 0,0,0);
    add(0,1,0,0,0,M0, 0,3, 0,0,1);
    add(0,1,0,0,0,M0, 0,3, 0,0,1);
    add(0,0,0,0,0,M0, 0,3, 0,0,1);
    add(0,1,0,0,0,M0, 1,3, 0,0,1);
    add(0,0,0,0,0,M0, 1,3, 0,0,1);
    // Goal cell also occupied: collision has priority.
    for (int k = 2; k <= 7; k++) begin
      add(0,1,0,0,0,M59, 3'(k),3, 0,0,1);
      if (k < 7) add(0,0,0,0,0,M59, 3'(k),3, 0,0,1);
    end
    add(0,0,0,0,0,M59, 7,3, 0,1,0);
    add(0,0,0,0,0,M0,  7,3, 0,0,0);  // FIN, frozen
    add(0,1,0,0,0,M0,  7,3, 0,0,0);  // press in FIN ignored

    // ---------------- reset values ----------------
    drive(1,0,0,0,0,0,M0);
    rst_n = 1'b0;
    #12;
    chk("reset_outs", 32'(outs()), 32'({3'd0, 3'd3, 1'b0, 1'b0, 1'b0}));
    chk("reset_tiempo", 32'(bus.CPR_TIEMPO_OUT), 32'd45);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- table run ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ini, vecs[i].up, vecs[i].down, vecs[i].left, vecs[i].right,
            1'b0, vecs[i].mapa);
      step();
      if (outs() !== {vecs[i].fila, vecs[i].col, vecs[i].gano, vecs[i].perdio, vecs[i].activa}) begin
        n_err++;
        $display("FAIL vec%0d {fila,col,g,p,a}: got %0d,%0d,%b,%b,%b expected %0d,%0d,%b,%b,%b",
                 i, bus.CPR_FILA_OUT, bus.CPR_COL_OUT, bus.CPR_GANO_OUT,
                 bus.CPR_PERDIO_OUT, bus.CPR_ACTIVA_OUT, vecs[i].fila, vecs[i].col,
                 vecs[i].gano, vecs[i].perdio, vecs[i].activa);
      end
      n_chk++;
    end

    // ---------------- timer ----------------
    drive(1,0,0,0,0,0,M0); step();
    chk("tiempo_armed", 32'(bus.CPR_TIEMPO_OUT), 32'd45);
    drive(1,0,0,0,0,1,M0); step();
    chk("tiempo_frozen_armada", 32'(bus.CPR_TIEMPO_OUT), 32'd45);
    drive(0,0,0,0,0,0,M0); step();
    chk("timer_juego", 32'(bus.CPR_ACTIVA_OUT), 32'd1);
    pulses = 0;
    for (int i = 0; i < 45; i++) begin
      drive(0,0,0,0,0,1,M0); step();
      if (bus.CPR_PERDIO_OUT) pulses++;
    end
`ifdef CPR_TIMEOUT_EN
    chk("tiempo_zero", 32'(bus.CPR_TIEMPO_OUT), 32'd0);
    chk("timer_still_active", 32'(bus.CPR_ACTIVA_OUT), 32'd1);
    chk("timer_no_early_pulse", 32'(pulses), 32'd0);
    drive(0,0,0,0,0,0,M0); step();
    chk("timeout_pulse", 32'(bus.CPR_PERDIO_OUT), 32'd1);
    step();
    chk("timeout_fin", 32'({bus.CPR_PERDIO_OUT, bus.CPR_ACTIVA_OUT}), 32'd0);
    chk("tiempo_frozen_fin", 32'(bus.CPR_TIEMPO_OUT), 32'd0);
`else
    for (int i = 0; i < 10; i++) begin
      drive(0,0,0,0,0,1,M0); step();
      if (bus.CPR_PERDIO_OUT) pulses++;
    end
    chk("notimer_no_pulse", 32'(pulses), 32'd0);
    chk("notimer_active", 32'(bus.CPR_ACTIVA_OUT), 32'd1);
    chk("notimer_tiempo", 32'(bus.CPR_TIEMPO_OUT), 32'd45);
`endif

    // ---------------- mid-game reset ----------------
    drive(1,0,0,0,0,0,M0); step();
    drive(0,0,0,0,0,0,M0); step();
    for (int k = 0; k < 4; k++) begin
      drive(0,1,0,0,0,0,M0); step();
      drive(0,0,0,0,0,0,M0); step();
    end
    chk("pre_reset_fila", 32'(bus.CPR_FILA_OUT), 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outs", 32'(outs()), 32'({3'd0, 3'd3, 1'b0, 1'b0, 1'b0}));
    chk("async_reset_tiempo", 32'(bus.CPR_TIEMPO_OUT), 32'd45);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.CPR_GANO_OUT || bus.CPR_PERDIO_OUT || bus.CPR_ACTIVA_OUT) pulses++;
    end
    chk("post_reset_idle", 32'(pulses), 32'd0);
    chk("post_reset_pos", 32'({bus.CPR_FILA_OUT, bus.CPR_COL_OUT}), 32'({3'd0, 3'd3}));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
